// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM.
// Holds the sequencer state encoding, read-latency limits and mask expansion.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } ram_state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;
    localparam int MAX_LANES    = 256;

    // Bit enable for data bit bit_idx: taken from the mask bit of the lane it belongs to.
    function automatic logic lane_bit_en(
        input logic [MAX_LANES-1:0] mask,
        input int                   bit_idx,
        input int                   lane_w
    );
        return mask[bit_idx / lane_w];
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Load-data pipeline: STAGES deep data+valid shift register.
// Data stages only advance on valid, so the output holds its last value between loads.
module ram_rd_pipe #(
    parameter int WIDTH  = 20,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic             w_vin;
            logic [WIDTH-1:0] w_din;

            if (gi == 0) begin : g_first
                assign w_vin = i_valid;
                assign w_din = i_data;
            end else begin : g_next
                assign w_vin = g_stage[gi-1].r_valid;
                assign w_din = g_stage[gi-1].r_data;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= w_vin;
                    if (w_vin) begin
                        r_data <= w_din;
                    end
                end
            end
        end
    endgenerate

    assign o_valid = g_stage[STAGES-1].r_valid;
    assign o_data  = g_stage[STAGES-1].r_data;

endmodule

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with per-lane write mask, pipelined load path
// and a post-reset clear sequencer that zeroes the whole array.
module ram_sync
    import ram_pkg::*;
#(
    parameter int WIDTH        = 20,
    parameter int DEPTH        = 1024,
    parameter int AW           = $clog2(DEPTH),
    parameter int LANE_W       = 10,
    parameter int LANES        = WIDTH / LANE_W,
    parameter int READ_LAT     = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] write,
    input  logic [LANES-1:0] wmask,
    input  logic             str,
    input  logic             ld,
    output logic [WIDTH-1:0] read,
    output logic             rvalid,
    output logic             busy
);

    generate
        if (WIDTH % LANE_W != 0) begin : g_bad_lane
            $error("ram_sync: WIDTH must be a multiple of LANE_W");
        end
        if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
            $error("ram_sync: READ_LAT must be 1 or 2");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ram_sync: DEPTH must be a power of two, at least 2");
        end
        if (LANES > MAX_LANES) begin : g_bad_lanes
            $error("ram_sync: too many write lanes");
        end
    endgenerate

    ram_state_t       r_state;
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_clear;
    logic             w_idle;
    logic             w_st_ok;
    logic             w_ld_ok;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_bit_en;
    logic [WIDTH-1:0] w_mem_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == AW'(DEPTH - 1)) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Requests are gated by rst_n so nothing touches the array while reset is held.
    assign w_clear = rst_n && (r_state == ST_CLEAR);
    assign w_idle  = rst_n && (r_state == ST_IDLE);
    assign w_st_ok = w_idle && str;
    assign w_ld_ok = w_idle && ld;

    assign w_we    = w_clear || w_st_ok;
    assign w_waddr = w_clear ? r_cnt : addr;
    assign w_wdata = w_clear ? '0 : write;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit_en
            assign w_bit_en[gi] = w_clear || lane_bit_en(MAX_LANES'(wmask), gi, LANE_W);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (w_bit_en[b]) begin
                    r_mem[w_waddr][b] <= w_wdata[b];
                end
            end
        end
    end

    // The array is sampled at the same edge as a colliding store, so loads see the old word.
    assign w_mem_rd = r_mem[addr];

    ram_rd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (READ_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_ld_ok),
        .i_data  (w_mem_rd),
        .o_valid (rvalid),
        .o_data  (read)
    );

    assign busy = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync.sv
// Directed self-checking bench for ram_sync with a 16-word array.
module tb_ram_sync;

    localparam int WIDTH    = 20;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int LANE_W   = 10;
    localparam int LANES    = 2;
    localparam int READ_LAT = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] write;
    logic [LANES-1:0] wmask;
    logic             str;
    logic             ld;
    logic [WIDTH-1:0] read;
    logic             rvalid;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_sync #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .LANE_W       (LANE_W),
        .READ_LAT     (READ_LAT),
        .CLEAR_ON_RST (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .write  (write),
        .wmask  (wmask),
        .str    (str),
        .ld     (ld),
        .read   (read),
        .rvalid (rvalid),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                            input logic [LANES-1:0] m);
        addr = a; write = d; wmask = m; str = 1'b1;
        tick();
        str = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp, input string tag);
        addr = a; ld = 1'b1;
        tick();
        ld = 1'b0;
        repeat (READ_LAT - 1) tick();
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_read"}, 32'(read), 32'(exp));
    endtask

    // Counts busy cycles from the current sample while str/ld to addr 2 are held high.
    task automatic count_clear(input string tag);
        int cnt;
        logic seen_rv;
        cnt = 0;
        seen_rv = 1'b0;
        addr = 4'd2; write = 20'h55555; wmask = 2'b11; str = 1'b1; ld = 1'b1;
        while (busy === 1'b1 && cnt < 40) begin
            if (rvalid !== 1'b0) seen_rv = 1'b1;
            cnt++;
            tick();
        end
        str = 1'b0; ld = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'(DEPTH));
        chk({tag, "_no_rvalid"}, 32'(seen_rv), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; write = '0; wmask = '0; str = 1'b0; ld = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_read", 32'(read), 32'd0);

        rst_n = 1'b1;
        count_clear("clear1");
        chk("idle_busy", 32'(busy), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            do_load(AW'(a), 20'h0, $sformatf("clr_ld%0d", a));
        end

        do_store(4'd5, 20'hABCDE, 2'b11);
        do_load(4'd5, 20'hABCDE, "st_ld5");

        do_store(4'd3, 20'h12345, 2'b11);
        do_store(4'd3, 20'hFFFFF, 2'b01);
        do_load(4'd3, 20'h123FF, "mask_lo");
        do_store(4'd3, 20'h00000, 2'b10);
        do_load(4'd3, 20'h003FF, "mask_hi");
        do_store(4'd3, 20'hAAAAA, 2'b00);
        do_load(4'd3, 20'h003FF, "mask_none");

        do_store(4'd7, 20'h00001, 2'b11);
        addr = 4'd7; write = 20'h00002; wmask = 2'b11; str = 1'b1; ld = 1'b1;
        tick();
        str = 1'b0; ld = 1'b0;
        repeat (READ_LAT - 1) tick();
        chk("coll_rvalid", 32'(rvalid), 32'd1);
        chk("coll_old", 32'(read), 32'h00001);
        do_load(4'd7, 20'h00002, "coll_new");

        for (int i = 0; i < 4; i++) do_store(AW'(i), WIDTH'(i + 1), 2'b11);
        for (int c = 0; c < 4 + READ_LAT - 1; c++) begin
            if (c < 4) begin
                addr = AW'(c); ld = 1'b1;
            end else begin
                ld = 1'b0;
            end
            tick();
            if (c >= READ_LAT - 1) begin
                chk($sformatf("pipe%0d_rvalid", c - READ_LAT + 1), 32'(rvalid), 32'd1);
                chk($sformatf("pipe%0d_read", c - READ_LAT + 1), 32'(read), 32'(c - READ_LAT + 2));
            end
        end
        ld = 1'b0;
        tick();
        chk("hold_rvalid", 32'(rvalid), 32'd0);
        chk("hold_read", 32'(read), 32'd4);

        addr = 4'd1; ld = 1'b1; rst_n = 1'b0;
        tick();
        ld = 1'b0;
        chk("rst_ld_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ld_read", 32'(read), 32'd0);
        chk("rst_ld_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;

        addr = 4'd2; write = 20'h55555; wmask = 2'b11; str = 1'b1; ld = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_clear("clear2");
        do_load(4'd2, 20'h0, "post_clr2");
        do_load(4'd3, 20'h0, "post_clr3");
        do_load(4'd5, 20'h0, "post_clr5");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
